// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, ALU and branch codes,
// and the control bundle carried through the ID/EX register.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEQ  = 2'd1,
    BR_BNE  = 2'd2
  } br_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    br_e     branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE};

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline register outputs as seen by the EX stage.
interface id_ex_stage_if #(
  parameter int DW  = 32,
  parameter int RAW = 5
) ();
  logic           ex_valid;
  logic [DW-1:0]  ex_pc4;
  logic [DW-1:0]  ex_rs_val;
  logic [DW-1:0]  ex_rt_val;
  logic [DW-1:0]  ex_imm;
  logic [RAW-1:0] ex_rs;
  logic [RAW-1:0] ex_rt;
  logic [RAW-1:0] ex_dest;
  logic [2:0]     ex_alu_op;
  logic           ex_alu_src;
  logic           ex_mem_read;
  logic           ex_mem_write;
  logic           ex_reg_write;
  logic [1:0]     ex_branch;

  modport master (
    output ex_valid, ex_pc4, ex_rs_val, ex_rt_val, ex_imm, ex_rs, ex_rt, ex_dest,
           ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch
  );
  modport slave (
    input  ex_valid, ex_pc4, ex_rs_val, ex_rt_val, ex_imm, ex_rs, ex_rt, ex_dest,
           ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch
  );
endinterface

// File: rtl/mips_decoder.sv
// Combinational instruction decoder: control bundle, immediate, destination
// register and operand-usage flags for hazard detection.
module mips_decoder
  import mips_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic [31:0]    instr,
  output ctrl_t          ctrl,
  output logic [DW-1:0]  imm,
  output logic [RAW-1:0] rs,
  output logic [RAW-1:0] rt,
  output logic [RAW-1:0] dest,
  output logic           uses_rs,
  output logic           uses_rt,
  output logic           is_j
);

  logic [DW-1:0] imm_sx;
  logic [DW-1:0] imm_zx;

  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign imm_sx = {{(DW-16){instr[15]}}, instr[15:0]};
  assign imm_zx = {{(DW-16){1'b0}}, instr[15:0]};

  always_comb begin
    ctrl    = CTRL_NOP;
    imm     = '0;
    dest    = '0;
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    is_j    = 1'b0;
    case (instr[31:26])
      OP_RTYPE: begin
        uses_rt        = 1'b1;
        ctrl.reg_write = 1'b1;
        dest           = instr[15:11];
        case (instr[5:0])
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          // Unknown funct falls back to a NOP with no register write.
          default: begin
            ctrl.reg_write = 1'b0;
            dest           = '0;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        imm = imm_sx; dest = instr[20:16];
      end
      OP_ANDI: begin
        ctrl.alu_op = ALU_AND; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        imm = imm_zx; dest = instr[20:16];
      end
      OP_ORI: begin
        ctrl.alu_op = ALU_OR; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
        imm = imm_zx; dest = instr[20:16];
      end
      OP_LW: begin
        ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.reg_write = 1'b1;
        imm = imm_sx; dest = instr[20:16];
      end
      OP_SW: begin
        ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1;
        imm = imm_sx; uses_rt = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB; ctrl.branch = BR_BEQ;
        imm = imm_sx; uses_rt = 1'b1;
      end
      OP_BNE: begin
        ctrl.alu_op = ALU_SUB; ctrl.branch = BR_BNE;
        imm = imm_sx; uses_rt = 1'b1;
      end
      OP_J: begin
        is_j    = 1'b1;
        uses_rs = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage with load-use hazard detection and the ID/EX pipeline register.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ifid_valid,
  input  logic [31:0]    ifid_instr,
  input  logic [DW-1:0]  ifid_pc4,
  output logic [RAW-1:0] rs_addr,
  output logic [RAW-1:0] rt_addr,
  input  logic [DW-1:0]  rs_data,
  input  logic [DW-1:0]  rt_data,
  input  logic           freeze,
  input  logic           ex_flush,
  output logic           stall_ifid,
  output logic           id_jump,
  output logic [DW-1:0]  id_jump_target,
  id_ex_stage_if.master  ex
);

  typedef struct packed {
    logic           valid;
    logic [DW-1:0]  pc4;
    logic [DW-1:0]  rs_val;
    logic [DW-1:0]  rt_val;
    logic [DW-1:0]  imm;
    logic [RAW-1:0] rs;
    logic [RAW-1:0] rt;
    logic [RAW-1:0] dest;
    ctrl_t          ctrl;
  } idex_t;

  idex_t          r, nxt;
  ctrl_t          dec_ctrl;
  logic [DW-1:0]  dec_imm;
  logic [RAW-1:0] dec_rs, dec_rt, dec_dest;
  logic           uses_rs, uses_rt, is_j, hazard;

  mips_decoder #(.DW(DW), .RAW(RAW)) u_dec (
    .instr   (ifid_instr),
    .ctrl    (dec_ctrl),
    .imm     (dec_imm),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .dest    (dec_dest),
    .uses_rs (uses_rs),
    .uses_rt (uses_rt),
    .is_j    (is_j)
  );

  assign rs_addr = dec_rs;
  assign rt_addr = dec_rt;

  assign hazard = ifid_valid & r.valid & r.ctrl.mem_read & (r.dest != '0) &
                  ((uses_rs & (r.dest == dec_rs)) | (uses_rt & (r.dest == dec_rt)));

  assign stall_ifid     = hazard & ~ex_flush & ~freeze;
  assign id_jump        = ifid_valid & is_j & ~ex_flush & ~freeze;
  assign id_jump_target = {ifid_pc4[DW-1:DW-4], ifid_instr[25:0], 2'b00};

  always_comb begin
    nxt = r;
    if (!freeze) begin
      if (ex_flush || hazard || !ifid_valid) begin
        nxt = '0;
      end else begin
        nxt.valid  = 1'b1;
        nxt.pc4    = ifid_pc4;
        nxt.rs_val = rs_data;
        nxt.rt_val = rt_data;
        nxt.imm    = dec_imm;
        nxt.rs     = dec_rs;
        nxt.rt     = dec_rt;
        nxt.dest   = dec_dest;
        nxt.ctrl   = dec_ctrl;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r <= '0;
    else     r <= nxt;
  end

  assign ex.ex_valid     = r.valid;
  assign ex.ex_pc4       = r.pc4;
  assign ex.ex_rs_val    = r.rs_val;
  assign ex.ex_rt_val    = r.rt_val;
  assign ex.ex_imm       = r.imm;
  assign ex.ex_rs        = r.rs;
  assign ex.ex_rt        = r.rt;
  assign ex.ex_dest      = r.dest;
  assign ex.ex_alu_op    = r.ctrl.alu_op;
  assign ex.ex_alu_src   = r.ctrl.alu_src;
  assign ex.ex_mem_read  = r.ctrl.mem_read;
  assign ex.ex_mem_write = r.ctrl.mem_write;
  assign ex.ex_reg_write = r.ctrl.reg_write;
  assign ex.ex_branch    = r.ctrl.branch;

endmodule
